// File: rtl/riscv_pkg.sv
// ============================================================================
// riscv_pkg : load Funct3 encodings and MEM/WB skid-buffer state encoding
// Revision  : 1.0
// ============================================================================
`default_nettype none

package riscv_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/mem_wb_stage_load_align.sv
// ============================================================================
// load_align : byte/half/word lane extraction and extension for loads
// Macro      : MEM_WB_MISALIGN_TRAP_EN enables the misalign flag (else tied 0)
// Revision   : 1.0
// ============================================================================
`default_nettype none

module load_align
  import riscv_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        Funct3,
  input  logic [1:0]        addr_lo,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] data,
  output logic              misalign
);

  logic [DATA_W-1:0] lane_w;
  logic [7:0]        byte_w;
  logic [15:0]       half_w;

  assign lane_w = mem_rdata >> {addr_lo, 3'b000};
  assign byte_w = lane_w[7:0];
  assign half_w = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    data = mem_rdata;
    case (Funct3)
      F3_LB:   data = {{(DATA_W-8){byte_w[7]}}, byte_w};
      F3_LH:   data = {{(DATA_W-16){half_w[15]}}, half_w};
      F3_LBU:  data = {{(DATA_W-8){1'b0}}, byte_w};
      F3_LHU:  data = {{(DATA_W-16){1'b0}}, half_w};
      default: data = mem_rdata;
    endcase
  end

`ifdef MEM_WB_MISALIGN_TRAP_EN
  assign misalign = (((Funct3 == F3_LH) || (Funct3 == F3_LHU)) && addr_lo[0]) ||
                    ((Funct3 == F3_LW) && (addr_lo != 2'b00));
`else
  assign misalign = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/mem_wb_stage.sv
// ============================================================================
// mem_wb_stage : MEM->WB register with load alignment and 2-entry skid buffer
// Macro        : MEM_WB_MISALIGN_TRAP_EN flags/suppresses misaligned loads
// Revision     : 1.0
// ============================================================================
`default_nettype none

module mem_wb_stage
  import riscv_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int DM_ADDRESS = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  input  logic              MemRead,
  input  logic              RegWrite,
  input  logic [2:0]        Funct3,
  input  logic [1:0]        addr_lo,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [4:0]        rd_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] wb_data,
  output logic [4:0]        wb_rd,
  output logic              wb_RegWrite,
  output logic              misalign
);

  if ((DM_ADDRESS < 2) || (DATA_W < 32)) begin : g_param_check
    $error("mem_wb_stage: DM_ADDRESS must be >= 2 and DATA_W >= 32");
  end

  state_e            state_q, state_d;
  logic              in_ready_q;
  logic [DATA_W-1:0] out_data_q, skid_data_q;
  logic [4:0]        out_rd_q, skid_rd_q;
  logic              out_we_q, skid_we_q;
  logic              out_mis_q, skid_mis_q;

  logic [DATA_W-1:0] la_data;
  logic              la_mis;
  logic [DATA_W-1:0] new_data;
  logic              new_mis, new_we;
  logic              accept, emit;
  logic              ld_out_new, ld_out_skid, ld_skid;

  load_align #(.DATA_W(DATA_W)) u_load_align (
    .Funct3    (Funct3),
    .addr_lo   (addr_lo),
    .mem_rdata (mem_rdata),
    .data      (la_data),
    .misalign  (la_mis)
  );

  // Payload is resolved at acceptance so skid entries never need realignment.
  assign new_data = MemRead ? la_data : alu_result;
  assign new_mis  = MemRead & la_mis;
  assign new_we   = RegWrite && (rd_addr != 5'd0) && !new_mis;

  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid && in_ready_q;
  assign emit      = out_valid && out_ready;

  always_comb begin
    state_d     = state_q;
    ld_out_new  = 1'b0;
    ld_out_skid = 1'b0;
    ld_skid     = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d    = ONE;
            ld_out_new = 1'b1;
          end
        end
        ONE: begin
          if (accept && !emit) begin
            state_d = FULL;
            ld_skid = 1'b1;
          end else if (accept && emit) begin
            ld_out_new = 1'b1;
          end else if (emit) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (emit) begin
            state_d     = ONE;
            ld_out_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_data_q  <= '0;
      out_rd_q    <= '0;
      out_we_q    <= 1'b0;
      out_mis_q   <= 1'b0;
      skid_data_q <= '0;
      skid_rd_q   <= '0;
      skid_we_q   <= 1'b0;
      skid_mis_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != FULL);
      if (ld_out_new) begin
        out_data_q <= new_data;
        out_rd_q   <= rd_addr;
        out_we_q   <= new_we;
        out_mis_q  <= new_mis;
      end else if (ld_out_skid) begin
        out_data_q <= skid_data_q;
        out_rd_q   <= skid_rd_q;
        out_we_q   <= skid_we_q;
        out_mis_q  <= skid_mis_q;
      end
      if (ld_skid) begin
        skid_data_q <= new_data;
        skid_rd_q   <= rd_addr;
        skid_we_q   <= new_we;
        skid_mis_q  <= new_mis;
      end
    end
  end

  assign in_ready    = in_ready_q;
  assign wb_data     = out_data_q;
  assign wb_rd       = out_rd_q;
  assign wb_RegWrite = out_we_q;
  assign misalign    = out_mis_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
// ============================================================================
// tb_mem_wb_stage : randomized + directed bench for mem_wb_stage (queue model)
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, flush, MemRead, RegWrite;
  logic [2:0]  Funct3;
  logic [1:0]  addr_lo;
  logic [31:0] alu_result, mem_rdata;
  logic [4:0]  rd_addr;
  logic        out_valid, out_ready;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_RegWrite, misalign;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
    logic        mis;
  } beat_t;

  beat_t q[$];

  mem_wb_stage #(.DATA_W(32), .DM_ADDRESS(9)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .flush       (flush),
    .MemRead     (MemRead),
    .RegWrite    (RegWrite),
    .Funct3      (Funct3),
    .addr_lo     (addr_lo),
    .alu_result  (alu_result),
    .mem_rdata   (mem_rdata),
    .rd_addr     (rd_addr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .wb_data     (wb_data),
    .wb_rd       (wb_rd),
    .wb_RegWrite (wb_RegWrite),
    .misalign    (misalign)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [1:0] a,
                                           input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * a)) & 32'hFF;
    h = (w >> (16 * a[1])) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
      3'd1:    return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  function automatic logic exp_mis(input logic mr, input logic [2:0] f3, input logic [1:0] a);
`ifdef MEM_WB_MISALIGN_TRAP_EN
    return mr && ((((f3 == 3'd1) || (f3 == 3'd5)) && a[0]) || ((f3 == 3'd2) && (a != 2'd0)));
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
    chk("in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
    if (q.size() > 0 && out_valid === 1'b1) begin
      chk("wb_data", wb_data, q[0].data);
      chk("wb_rd", {27'd0, wb_rd}, {27'd0, q[0].rd});
      chk("wb_RegWrite", {31'd0, wb_RegWrite}, {31'd0, q[0].we});
      chk("misalign", {31'd0, misalign}, {31'd0, q[0].mis});
    end
  endtask

  task automatic model_update();
    beat_t b;
    bit    can_take;
    if (!rst_n || flush) begin
      q.delete();
    end else begin
      can_take = (q.size() < 2);
      if (out_ready && q.size() > 0) void'(q.pop_front());
      if (in_valid && can_take) begin
        b.mis  = exp_mis(MemRead, Funct3, addr_lo);
        b.data = MemRead ? exp_load(Funct3, addr_lo, mem_rdata) : alu_result;
        b.rd   = rd_addr;
        b.we   = RegWrite && (rd_addr != 5'd0) && !b.mis;
        q.push_back(b);
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    compare();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drain();
    in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
    repeat (3) cycle();
  endtask

  task automatic load_beat(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] w,
                           input logic [31:0] exp, input string name);
    in_valid = 1'b1; out_ready = 1'b1; MemRead = 1'b1; RegWrite = 1'b1; rd_addr = 5'd7;
    Funct3 = f3; addr_lo = a; mem_rdata = w;
    cycle();
    chk(name, wb_data, exp);
  endtask

  task automatic alu_beat(input logic [31:0] v);
    in_valid = 1'b1; MemRead = 1'b0; RegWrite = 1'b1; rd_addr = 5'd3; alu_result = v;
    cycle();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; MemRead = 1'b0; RegWrite = 1'b0;
    Funct3 = 3'd0; addr_lo = 2'd0; alu_result = '0; mem_rdata = '0; rd_addr = '0;
    out_ready = 1'b0;
    repeat (2) cycle();
    chk("rst_wb_data", wb_data, 32'h0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;

    // Literal lane-extraction pins
    load_beat(3'd0, 2'd0, 32'h8000_FF7F, 32'h0000_007F, "LB_lane0");
    load_beat(3'd0, 2'd1, 32'h8000_FF7F, 32'hFFFF_FFFF, "LB_lane1");
    load_beat(3'd4, 2'd1, 32'h8000_FF7F, 32'h0000_00FF, "LBU_lane1");
    load_beat(3'd1, 2'd2, 32'h8000_1234, 32'hFFFF_8000, "LH_lane2");
    load_beat(3'd5, 2'd2, 32'h8000_1234, 32'h0000_8000, "LHU_lane2");
    drain();

    // Backpressure: three beats offered, two taken, then ordered drain
    out_ready = 1'b0;
    alu_beat(32'hA1);
    alu_beat(32'hB2);
    chk("bp_in_ready_full", {31'd0, in_ready}, 32'd0);
    alu_beat(32'hC3);
    chk("bp_head", wb_data, 32'hA1);
    in_valid = 1'b0; out_ready = 1'b1;
    cycle();
    chk("bp_second", wb_data, 32'hB2);
    chk("bp_in_ready_back", {31'd0, in_ready}, 32'd1);
    cycle();
    chk("bp_empty", {31'd0, out_valid}, 32'd0);

    // Flush from FULL with a simultaneous offer
    out_ready = 1'b0;
    alu_beat(32'h11);
    alu_beat(32'h22);
    flush = 1'b1; in_valid = 1'b1;
    cycle();
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
    flush = 1'b0; in_valid = 1'b0;
    cycle();
    chk("flush_stays_empty", {31'd0, out_valid}, 32'd0);

    // x0 destination and misaligned LW
    out_ready = 1'b1; in_valid = 1'b1; MemRead = 1'b0; RegWrite = 1'b1; rd_addr = 5'd0;
    cycle();
    chk("rd0_no_write", {31'd0, wb_RegWrite}, 32'd0);
    MemRead = 1'b1; Funct3 = 3'd2; addr_lo = 2'd2; rd_addr = 5'd9; mem_rdata = 32'hDEAD_BEEF;
    cycle();
`ifdef MEM_WB_MISALIGN_TRAP_EN
    chk("lw_mis_flag", {31'd0, misalign}, 32'd1);
    chk("lw_mis_we", {31'd0, wb_RegWrite}, 32'd0);
`else
    chk("lw_mis_flag", {31'd0, misalign}, 32'd0);
    chk("lw_mis_we", {31'd0, wb_RegWrite}, 32'd1);
`endif
    drain();

    // Randomized traffic against the queue model
    for (int i = 0; i < 3000; i++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 2) != 0);
      flush      = ($urandom_range(0, 29) == 0);
      MemRead    = $urandom_range(0, 1);
      RegWrite   = $urandom_range(0, 1);
      Funct3     = 3'($urandom_range(0, 7));
      addr_lo    = 2'($urandom_range(0, 3));
      rd_addr    = 5'($urandom_range(0, 31));
      alu_result = $urandom;
      mem_rdata  = $urandom;
      cycle();
    end
    flush = 1'b0;
    drain();

    // Asynchronous reset between edges while holding one beat
    out_ready = 1'b0; in_valid = 1'b1; MemRead = 1'b0; RegWrite = 1'b1;
    rd_addr = 5'd12; alu_result = 32'h5555_AAAA;
    cycle();
    in_valid = 1'b0;
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("arst_wb_data", wb_data, 32'h0);
    chk("arst_wb_rd", {27'd0, wb_rd}, 32'd0);
    chk("arst_wb_we", {31'd0, wb_RegWrite}, 32'd0);
    chk("arst_misalign", {31'd0, misalign}, 32'd0);
    q.delete();
    cycle();
    rst_n = 1'b1;
    out_ready = 1'b1;
    alu_beat(32'h0BAD_F00D);
    chk("post_rst_beat", wb_data, 32'h0BAD_F00D);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 Parameter DATA_W, default 32: datapath width.
REQ-002 Parameter DM_ADDRESS, default 9: data-memory address width; only bits [1:0] are consumed here.
REQ-003 clk  in  1: single clock; all state updates on rising edge.
REQ-004 rst_n  in  1: asynchronous, active-low reset.
REQ-005 in_valid  in  1: MEM-stage beat valid.
REQ-006 in_ready  out  1: stage can accept a beat.
REQ-007 flush  in  1: synchronous kill of all held beats.
REQ-008 MemRead  in  1: beat is a load.
REQ-009 RegWrite  in  1: beat writes the register file.
REQ-010 Funct3  in  3: instruction bits 14:12.
REQ-011 addr_lo  in  2: ALU result bits [1:0].
REQ-012 alu_result  in  DATA_W: non-load writeback value.
REQ-013 mem_rdata  in  DATA_W: raw 32-bit data-memory word, valid in the same cycle as in_valid.
REQ-014 rd_addr  in  5: destination register.
REQ-015 out_valid  out  1: WB beat valid.
REQ-016 out_ready  in  1: WB consumer accepts.
REQ-017 wb_data  out  DATA_W: aligned/extended writeback value.
REQ-018 wb_rd  out  5: destination register.
REQ-019 wb_RegWrite  out  1: register-file write enable.
REQ-020 misalign  out  1: misaligned-load flag.

Function
REQ-021 Accept when in_valid && in_ready; emit when out_valid && out_ready.
REQ-022 Load extraction (MemRead=1): 000 LB = sign-ext byte at lane addr_lo; 001 LH = sign-ext half at lane addr_lo[1]; 010 LW = full word; 100 LBU = zero-ext byte; 101 LHU = zero-ext half; other Funct3 = full word.
REQ-023 wb_data = extracted load value if MemRead else alu_result, computed at acceptance and registered.
REQ-024 wb_RegWrite = RegWrite && (rd_addr != 0).
REQ-025 Latency one cycle: a beat accepted at edge N is on the outputs after edge N.
REQ-026 Two-entry skid buffer, FSM states EMPTY, ONE, FULL; out_valid=0 only in EMPTY.
REQ-027 EMPTY: accept -> ONE. ONE: accept without emit -> FULL; emit without accept -> EMPTY; both or neither -> ONE. FULL: emit -> ONE (skid entry moves to output register); no accept possible.
REQ-028 in_ready is a registered signal, 1 in EMPTY/ONE, 0 in FULL; no combinational path from out_ready to in_ready.
REQ-029 Output order equals acceptance order; no beat dropped or duplicated.
REQ-030 flush forces EMPTY next cycle, outranks simultaneous accept and emit; accepted beat in that cycle is discarded.

Reset
REQ-031 rst_n low: state EMPTY, in_ready=1, out_valid=0, wb_data=0, wb_rd=0, wb_RegWrite=0, misalign=0, asynchronously.
REQ-032 Reset mid-transfer discards all held beats; first accept after release behaves as from EMPTY.

Configuration
REQ-033 Macro MEM_WB_MISALIGN_TRAP_EN defined: misalign=1 for LH/LHU with addr_lo[0]=1 or LW with addr_lo!=0; such beats have wb_RegWrite=0.
REQ-034 Macro undefined: misalign tied 0, no suppression, misaligned lanes extracted per REQ-022.

Structure
REQ-035 Shared package riscv_pkg holds Funct3 load-encoding constants and the state enum {EMPTY, ONE, FULL}.
REQ-036 Combinational sub-module load_align (Funct3, addr_lo, mem_rdata -> data, misalign) instanced once at the input.

Verification
REQ-037 mem_rdata=0x8000_FF7F, LB, addr_lo=0 -> wb_data=0x0000_007F; addr_lo=1, LB -> 0xFFFF_FFFF; LBU addr_lo=1 -> 0x0000_00FF.
REQ-038 mem_rdata=0x8000_1234, LH addr_lo=2 -> 0xFFFF_8000; LHU addr_lo=2 -> 0x0000_8000.
REQ-039 out_ready=0, three back-to-back in_valid beats -> two accepted, in_ready=0 after second; out_ready=1 then emits beats 1,2 in order, in_ready=1 one cycle after first emit.
REQ-040 State FULL, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, nothing emitted.
REQ-041 RegWrite=1, rd_addr=0 -> wb_RegWrite=0; with MEM_WB_MISALIGN_TRAP_EN, LW addr_lo=2 -> misalign=1, wb_RegWrite=0; without it misalign=0.
REQ-042 rst_n pulsed low in state ONE between edges -> outputs at reset values immediately, not at next edge.
